// File: rtl/count_check_pkg.sv
// Shared types and constants for the count sequence checker.
package count_check_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_LOCK_CNT = 4;
    localparam int DEF_ERR_W    = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // good_cnt must be able to hold 0..LOCK_CNT; never narrower than one bit.
    function automatic int good_cnt_width(input int lock_cnt);
        return (lock_cnt < 1) ? 1 : $clog2(lock_cnt + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/count_seq_checker.sv
// Locks onto an incrementing count stream and flags breaks in the sequence.
// Optional COUNT_CHECK_CAPTURE_EN adds capture of the first break after reset/clr.
module count_seq_checker
    import count_check_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LOCK_CNT = DEF_LOCK_CNT,
    parameter int ERR_W    = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] qin,
    input  logic             qin_valid,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
`ifdef COUNT_CHECK_CAPTURE_EN
    ,
    output logic             first_vld,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_got
`endif
);

    localparam int GW = good_cnt_width(LOCK_CNT);
    localparam logic [GW-1:0] LAST_GOOD = GW'(LOCK_CNT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] expected;
    logic [WIDTH-1:0] expected_nxt;
    logic [GW-1:0]    good_cnt;
    logic [GW-1:0]    good_nxt;
    logic             err_nxt;
    logic             lock_break;
    logic             match;
    logic [WIDTH-1:0] qin_inc;

    assign match   = (qin == expected);
    assign qin_inc = qin + WIDTH'(1);
    assign locked  = (state == LOCKED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            expected <= '0;
            good_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            expected <= expected_nxt;
            good_cnt <= good_nxt;
            err      <= err_nxt;
        end
    end

    // Every sample resyncs expected to qin+1, so a break never cascades into more breaks.
    always_comb begin
        state_nxt    = state;
        expected_nxt = expected;
        good_nxt     = good_cnt;
        err_nxt      = 1'b0;
        lock_break   = 1'b0;
        if (clr) begin
            state_nxt = IDLE;
            good_nxt  = '0;
        end else if (qin_valid) begin
            expected_nxt = qin_inc;
            case (state)
                IDLE: begin
                    good_nxt  = '0;
                    state_nxt = ACQUIRE;
                end
                ACQUIRE: begin
                    if (match) begin
                        good_nxt = good_cnt + 1'b1;
                        if (good_cnt == LAST_GOOD) begin
                            state_nxt = LOCKED;
                        end
                    end else begin
                        good_nxt = '0;
                    end
                end
                LOCKED: begin
                    if (!match) begin
                        err_nxt    = 1'b1;
                        lock_break = 1'b1;
                        good_nxt   = '0;
                        state_nxt  = ACQUIRE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    good_nxt  = '0;
                end
            endcase
        end
    end

    sat_counter #(
        .W(ERR_W)
    ) u_err_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (lock_break),
        .clr  (clr),
        .count(err_cnt)
    );

`ifdef COUNT_CHECK_CAPTURE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_vld <= 1'b0;
            first_exp <= '0;
            first_got <= '0;
        end else if (clr) begin
            first_vld <= 1'b0;
            first_exp <= '0;
            first_got <= '0;
        end else if (lock_break && !first_vld) begin
            first_vld <= 1'b1;
            first_exp <= expected;
            first_got <= qin;
        end
    end
`endif

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker; a second instance with ERR_W=2 covers saturation.
module tb_count_seq_checker;

    logic       clk;
    logic       reset;
    logic [7:0] qin;
    logic       qin_valid;
    logic       clr;

    logic        locked;
    logic        err;
    logic [15:0] err_cnt;
    logic        sat_locked;
    logic        sat_err;
    logic [1:0]  sat_err_cnt;
`ifdef COUNT_CHECK_CAPTURE_EN
    logic       first_vld;
    logic [7:0] first_exp;
    logic [7:0] first_got;
    logic       sat_first_vld;
    logic [7:0] sat_first_exp;
    logic [7:0] sat_first_got;
`endif

    int check_count = 0;
    int pass_count  = 0;

    count_seq_checker #(.WIDTH(8), .LOCK_CNT(4), .ERR_W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .qin      (qin),
        .qin_valid(qin_valid),
        .clr      (clr),
        .locked   (locked),
        .err      (err),
        .err_cnt  (err_cnt)
`ifdef COUNT_CHECK_CAPTURE_EN
        ,
        .first_vld(first_vld),
        .first_exp(first_exp),
        .first_got(first_got)
`endif
    );

    count_seq_checker #(.WIDTH(8), .LOCK_CNT(4), .ERR_W(2)) dut_sat (
        .clk      (clk),
        .reset    (reset),
        .qin      (qin),
        .qin_valid(qin_valid),
        .clr      (clr),
        .locked   (sat_locked),
        .err      (sat_err),
        .err_cnt  (sat_err_cnt)
`ifdef COUNT_CHECK_CAPTURE_EN
        ,
        .first_vld(sat_first_vld),
        .first_exp(sat_first_exp),
        .first_got(sat_first_got)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive on the falling edge, return 1 time unit after the next rising edge.
    task automatic applyStimulus(input logic v, input logic [7:0] q, input logic c);
        @(negedge clk);
        qin_valid = v;
        qin       = q;
        clr       = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] cur;
        reset     = 1'b1;
        qin       = 8'd0;
        qin_valid = 1'b0;
        clr       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_locked", locked, 0);
        checkOutput("reset_err", err, 0);
        checkOutput("reset_err_cnt", err_cnt, 0);
        @(negedge clk);
        reset = 1'b0;

        // Basic lock on 0..4
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0);
            checkOutput($sformatf("lock_locked_%0d", i), locked, (i == 4) ? 1 : 0);
            checkOutput($sformatf("lock_err_%0d", i), err, 0);
        end
        checkOutput("lock_err_cnt", err_cnt, 0);

        // Wrap through 255 -> 0
        applyStimulus(1'b0, 8'd0, 1'b1);
        checkOutput("clr_unlocks", locked, 0);
        applyStimulus(1'b1, 8'd253, 1'b0);
        applyStimulus(1'b1, 8'd254, 1'b0);
        applyStimulus(1'b1, 8'd255, 1'b0);
        applyStimulus(1'b1, 8'd0, 1'b0);
        checkOutput("wrap_not_yet", locked, 0);
        checkOutput("wrap_err0", err, 0);
        applyStimulus(1'b1, 8'd1, 1'b0);
        checkOutput("wrap_locked", locked, 1);
        applyStimulus(1'b1, 8'd2, 1'b0);
        checkOutput("wrap_still_locked", locked, 1);
        checkOutput("wrap_err_cnt", err_cnt, 0);

        // Break while locked: 10,11,13..17
        applyStimulus(1'b0, 8'd0, 1'b1);
        for (int i = 6; i <= 11; i++) applyStimulus(1'b1, 8'(i), 1'b0);
        checkOutput("brk_locked_pre", locked, 1);
        applyStimulus(1'b1, 8'd13, 1'b0);
        checkOutput("brk_err", err, 1);
        checkOutput("brk_err_cnt", err_cnt, 1);
        checkOutput("brk_unlocked", locked, 0);
`ifdef COUNT_CHECK_CAPTURE_EN
        checkOutput("brk_first_vld", first_vld, 1);
        checkOutput("brk_first_exp", first_exp, 12);
        checkOutput("brk_first_got", first_got, 13);
`endif
        applyStimulus(1'b1, 8'd14, 1'b0);
        checkOutput("brk_err_pulse", err, 0);
        applyStimulus(1'b1, 8'd15, 1'b0);
        applyStimulus(1'b1, 8'd16, 1'b0);
        checkOutput("brk_relock_early", locked, 0);
        applyStimulus(1'b1, 8'd17, 1'b0);
        checkOutput("brk_relocked", locked, 1);
        checkOutput("brk_err_cnt_hold", err_cnt, 1);

        // clr on a mismatch edge wins
        applyStimulus(1'b1, 8'd50, 1'b1);
        checkOutput("clrmm_err", err, 0);
        checkOutput("clrmm_err_cnt", err_cnt, 0);
        checkOutput("clrmm_locked", locked, 0);
`ifdef COUNT_CHECK_CAPTURE_EN
        checkOutput("clrmm_first_vld", first_vld, 0);
`endif

        // Gaps with garbage qin do not disturb lock
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 8'(i), 1'b0);
        checkOutput("gap_locked_pre", locked, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'd99, 1'b0);
            checkOutput($sformatf("gap_err_%0d", i), err, 0);
            checkOutput($sformatf("gap_locked_%0d", i), locked, 1);
        end
        applyStimulus(1'b1, 8'd6, 1'b0);
        checkOutput("gap_after_err", err, 0);
        checkOutput("gap_after_locked", locked, 1);

        // Back-to-back mismatches give one err
        applyStimulus(1'b1, 8'd20, 1'b0);
        checkOutput("b2b_err1", err, 1);
        applyStimulus(1'b1, 8'd40, 1'b0);
        checkOutput("b2b_err2", err, 0);
        checkOutput("b2b_err_cnt", err_cnt, 1);
`ifdef COUNT_CHECK_CAPTURE_EN
        checkOutput("b2b_first_exp", first_exp, 7);
        checkOutput("b2b_first_got", first_got, 20);
`endif

        // Saturation: five lock/break cycles
        applyStimulus(1'b0, 8'd0, 1'b1);
        for (int i = 100; i <= 104; i++) applyStimulus(1'b1, 8'(i), 1'b0);
        cur = 8'd104;
        for (int i = 0; i < 5; i++) begin
            cur = cur + 8'd10;
            applyStimulus(1'b1, cur, 1'b0);
            checkOutput($sformatf("sat_err_%0d", i), sat_err, 1);
            checkOutput($sformatf("sat_cnt_%0d", i), sat_err_cnt, (i < 2) ? i + 1 : 3);
            checkOutput($sformatf("wide_cnt_%0d", i), err_cnt, i + 1);
            for (int j = 0; j < 4; j++) begin
                cur = cur + 8'd1;
                applyStimulus(1'b1, cur, 1'b0);
            end
            checkOutput($sformatf("sat_relock_%0d", i), sat_locked, 1);
        end
`ifdef COUNT_CHECK_CAPTURE_EN
        checkOutput("sat_first_exp", first_exp, 105);
        checkOutput("sat_first_got", first_got, 114);
`endif

        // Async reset mid-cycle with err high
        applyStimulus(1'b1, cur + 8'd10, 1'b0);
        checkOutput("ar_err_pre", err, 1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("ar_locked", locked, 0);
        checkOutput("ar_err", err, 0);
        checkOutput("ar_err_cnt", err_cnt, 0);
        checkOutput("ar_sat_err_cnt", sat_err_cnt, 0);
        qin_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'(i + 30), 1'b0);
            checkOutput($sformatf("ar_relock_%0d", i), locked, (i == 4) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
